// File: rtl/johnson_pkg.sv
// Shared types for the Johnson counter run controller: FSM state encoding
// and shift-direction constants.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : johnson_pkg

// File: rtl/johnson_core.sv
// WIDTH-bit Johnson (twisted-ring) shift register with synchronous clear
// and step enable; direction selects which end receives the inverted bit.
module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_code;
  logic [WIDTH-1:0] w_code_next;

  always_comb begin
    w_code_next = r_code;
    if (clr) begin
      w_code_next = '0;
    end else if (en) begin
      if (dir == DIR_RIGHT) begin
        w_code_next = {~r_code[0], r_code[WIDTH-1:1]};
      end else begin
        w_code_next = {r_code[WIDTH-2:0], ~r_code[WIDTH-1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_code <= '0;
    end else begin
      r_code <= w_code_next;
    end
  end

  assign out = r_code;

endmodule : johnson_core

// File: rtl/johnson_seq_ctrl.sv
// Run controller: sequences a Johnson counter through a programmed number of
// full rounds with pause/stop, and produces phase strobe and busy/done status.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               dir,
  input  logic [CNT_W-1:0]   rounds,
  output logic [WIDTH-1:0]   out,
  output logic [2*WIDTH-1:0] phase,
  output logic [CNT_W-1:0]   round_cnt,
  output logic               busy,
  output logic               done
);

  localparam int               PW     = 2 * WIDTH;
  localparam logic [PW-1:0]    PHASE0 = PW'(1);
  localparam logic [CNT_W-1:0] CNT1   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_dir;
  logic [CNT_W-1:0] r_rounds;
  logic [PW-1:0]    r_phase;
  logic [PW-1:0]    w_phase_next;
  logic [CNT_W-1:0] r_round_cnt;
  logic [CNT_W-1:0] w_round_cnt_next;
  logic [CNT_W-1:0] w_round_inc;
  logic             r_busy;
  logic             r_done;
  logic             w_capture;
  logic             w_clr;
  logic             w_en;

  johnson_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .dir   (r_dir),
    .out   (out)
  );

  assign w_round_inc = r_round_cnt + CNT1;

  // HOLD leaving on pause=0 steps on that same edge, so a pause costs exactly
  // as many cycles as it was held high.
  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_round_cnt_next = r_round_cnt;
    w_capture        = 1'b0;
    w_clr            = 1'b0;
    w_en             = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_state_next     = RUN;
          w_capture        = 1'b1;
          w_round_cnt_next = '0;
        end
      end
      RUN, HOLD: begin
        if (stop) begin
          w_state_next     = IDLE;
          w_clr            = 1'b1;
          w_phase_next     = PHASE0;
          w_round_cnt_next = '0;
        end else if (pause) begin
          w_state_next = HOLD;
        end else begin
          w_state_next = RUN;
          w_en         = 1'b1;
          w_phase_next = {r_phase[PW-2:0], r_phase[PW-1]};
          // Top phase bit marks the step that returns the code to zero.
          if (r_phase[PW-1]) begin
            w_round_cnt_next = w_round_inc;
            if ((r_rounds != '0) && (w_round_inc == r_rounds)) begin
              w_state_next = FINISH;
            end
          end
        end
      end
      FINISH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next     = IDLE;
        w_clr            = 1'b1;
        w_phase_next     = PHASE0;
        w_round_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_dir       <= DIR_LEFT;
      r_rounds    <= '0;
      r_phase     <= PHASE0;
      r_round_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_round_cnt <= w_round_cnt_next;
      r_busy      <= (w_state_next == RUN) || (w_state_next == HOLD);
      r_done      <= (w_state_next == FINISH);
      if (w_capture) begin
        r_dir    <= dir;
        r_rounds <= rounds;
      end
    end
  end

  assign phase     = r_phase;
  assign round_cnt = r_round_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule : johnson_seq_ctrl

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Run controller for a WIDTH-bit Johnson (twisted-ring) counter.
- Starts the counter on command and sequences it through a programmed number of full rounds of 2*WIDTH states, with pause, stop and direction control.
- Outputs the counter code, a one-hot phase strobe for downstream timing logic, and busy/done status.
- Sits between a host/control FSM and any logic that consumes multi-phase enables.

Parameters:
- WIDTH, 4, Johnson counter width; one round = 2*WIDTH steps; WIDTH >= 2.
- CNT_W, 8, width of rounds / round_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled each clk; ignored unless IDLE.
- stop  input  1  abort request; effective in RUN/HOLD.
- pause  input  1  level; freezes stepping while high.
- dir  input  1  0 = shift left, 1 = shift right; captured at start.
- rounds  input  CNT_W  rounds to run; 0 = run until stop; captured at start.
- out  output  WIDTH  Johnson counter code.
- phase  output  2*WIDTH  one-hot step index within the current round.
- round_cnt  output  CNT_W  completed rounds in the current run.
- busy  output  1  high in RUN and HOLD.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (reset=0, async): state=IDLE, out=0, phase=1 (bit0), round_cnt=0, busy=0, done=0, captured dir/rounds=0.
- States: IDLE, RUN, HOLD, FINISH.
- Step, dir=0: out <= {out[WIDTH-2:0], ~out[WIDTH-1]}. Sequence for WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000,0000.
- Step, dir=1: out <= {~out[0], out[WIDTH-1:1]}. Sequence: 0000,1000,1100,1110,1111,0111,0011,0001,0000.
- phase rotates left by one on every step, independent of dir. phase=bit0 exactly when out=0.
- IDLE: out=0, phase=bit0.
  - start=1 and stop=0: capture dir and rounds, clear round_cnt, go to RUN. out does not change on this edge.
  - start and stop in the same cycle: stop wins; stay IDLE.
- RUN: priority is stop > pause > step.
  - stop: out=0, phase=bit0, round_cnt=0, go to IDLE, no done pulse.
  - pause: go to HOLD with no step.
  - Otherwise step.
  - When a step returns out to 0 (the 2*WIDTH-th step of a round), round_cnt increments with CNT_W wrap.
  - If captured rounds != 0 and the incremented value equals rounds, go to FINISH.
- HOLD: out, phase and round_cnt frozen.
  - stop: same as in RUN.
  - pause=0: go to RUN. The next step happens on the edge after pause falls. Pause adds exactly its high-cycle count to run length.
- FINISH: one cycle. busy=0, done=1, out=0, round_cnt keeps its final value. Next edge goes to IDLE and done returns to 0.
  - start during FINISH is ignored.
  - stop during FINISH has no effect.
- Latency, rounds=R (R != 0), no pause: start sampled at edge t0; steps at t1..t(2*WIDTH*R); done high for the cycle after the last step edge.
- rounds=0: round_cnt wraps freely; the run ends only on stop or reset.
- dir and rounds changes while busy have no effect.
- Reset mid-run: immediate return to reset values; no done pulse.
- All outputs are registered (no combinational input-to-output path).

Decomposition:
- Shared package johnson_pkg: state enum (IDLE, RUN, HOLD, FINISH), DIR_LEFT=0 / DIR_RIGHT=1 constants.
- Sub-module johnson_core: WIDTH-bit shift register with ports clk, reset, clr, en, dir, out. The controller drives clr/en/dir and owns the phase, round and FSM logic.

Test Plan:
- Reset held low 2 cycles, then released -> out=0000, phase=00000001, busy=0, done=0, round_cnt=0.
- WIDTH=4, rounds=1, dir=0, start pulse -> out follows 0001,0011,0111,1111,1110,1100,1000,0000 on 8 consecutive edges. done pulses 1 cycle after the 8th step, round_cnt=1, busy falls.
- rounds=2, dir=1, pause high 3 cycles after the 3rd step (out=1110) -> out holds 1110 for 3 cycles, then resumes 1111. done arrives 16+3 step-cycles after start, round_cnt=2.
- rounds=0, stop asserted after 20 steps -> round_cnt=2 before stop, then out=0000, round_cnt=0, busy=0, no done pulse.
- start and stop in the same IDLE cycle -> remains IDLE, busy=0. start again during RUN with rounds changed -> ignored; original rounds honored.
- reset driven low mid-round (out=0111) -> out=0000, busy=0 asynchronously before the next edge. After release and a new start, the sequence restarts from 0001.
